// File: rtl/eight_to_three_event_encoder_pkg.sv
// Shared definitions for the event encoder: handshake FSM states and size limits.
package eight_to_three_event_encoder_pkg;

    // Largest supported number of request lines.
    localparam int N_MAX = 16;

    // Handshake FSM: IDLE looks for pending work, PRESENT holds a code until accepted.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/eight_to_three_event_encoder_prio.sv
// Combinational 4-to-2 priority encoder; bit 3 has the highest priority.
module four_to_two_prio (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    // Pick the highest set bit of the group and flag whether any bit is set.
    always_comb begin
        idx_o   = 2'd0;
        valid_o = |req_i;
        if (req_i[3]) begin
            idx_o = 2'd3;
        end else if (req_i[2]) begin
            idx_o = 2'd2;
        end else if (req_i[1]) begin
            idx_o = 2'd1;
        end else begin
            idx_o = 2'd0;
        end
    end

endmodule

// File: rtl/eight_to_three_event_encoder.sv
// Event encoder: captures rising edges of request lines into sticky pending
// bits and hands the highest-index pending request to a consumer as a binary
// code over a valid/ready handshake.
module eight_to_three_event_encoder
    import eight_to_three_event_encoder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] code,
    output logic                 code_valid,
    input  logic                 code_ready,
    output logic [N-1:0]         pending,
    output logic                 lost
);

    localparam int W      = $clog2(N);
    localparam int GROUPS = N / 4;

    // Registered state
    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic         lost_q;
    logic [W-1:0] code_q;
    logic         code_valid_q;
    state_e       state_q;

    // Next-state and combinational signals
    logic [N-1:0] pending_d;
    logic         lost_d;
    logic [N-1:0] rise_s;
    logic [N-1:0] clr_s;
    logic         handshake_s;
    logic [W-1:0] prio_idx_s;
    logic [1:0]   sub_idx_s [GROUPS];
    logic [GROUPS-1:0] sub_vld_s;

    // One priority encoder per group of four request lines.
    for (genvar g = 0; g < GROUPS; g++) begin : g_prio
        four_to_two_prio u_prio (
            .req_i   (pending_q[4*g +: 4]),
            .idx_o   (sub_idx_s[g]),
            .valid_o (sub_vld_s[g])
        );
    end

    // Highest non-empty group wins; its local index forms the low two code bits.
    always_comb begin
        prio_idx_s = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (sub_vld_s[g]) begin
                prio_idx_s = W'(4 * g) | W'(sub_idx_s[g]);
            end else begin
                prio_idx_s = prio_idx_s;
            end
        end
    end

    // Edge detect, acknowledge clear and next pending/lost values.
    always_comb begin
        rise_s      = req & ~req_q;
        handshake_s = code_valid_q & code_ready;
        clr_s       = '0;
        if (handshake_s) begin
            clr_s = {{(N-1){1'b0}}, 1'b1} << code_q;
        end else begin
            clr_s = '0;
        end
        if (enable) begin
            // A rise on the bit being cleared keeps it pending (set wins).
            pending_d = (pending_q & ~clr_s) | rise_s;
            lost_d    = |(rise_s & pending_q & ~clr_s);
        end else begin
            pending_d = pending_q & ~clr_s;
            lost_d    = 1'b0;
        end
    end

    // Request history, pending bits and lost pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            lost_q    <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    // Handshake FSM: launch a code from IDLE, hold it in PRESENT until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= '0;
            code_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && (|pending_q)) begin
                        code_q       <= prio_idx_s;
                        code_valid_q <= 1'b1;
                        state_q      <= PRESENT;
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                PRESENT: begin
                    // Later arrivals never preempt; enable is ignored here.
                    if (code_ready) begin
                        code_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        state_q      <= PRESENT;
                    end
                end
                default: begin
                    code_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign pending    = pending_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_eight_to_three_event_encoder.sv
// Directed bench for the event encoder with hand-computed expected values.
module tb_eight_to_three_event_encoder;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending;
    logic       lost;

    int checks;
    int errors;

    eight_to_three_event_encoder #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req        (req),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        enable     = 1'b1;
        req        = 8'h00;
        code_ready = 1'b0;
        #22;
        chk8("rst_pending", pending, 8'h00);
        chk3("rst_code", code, 3'd0);
        chk1("rst_valid", code_valid, 1'b0);
        chk1("rst_lost", lost, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single pulse on req[5]
        req = 8'h20;
        tick();
        chk8("t1_pending", pending, 8'h20);
        chk1("t1_valid_early", code_valid, 1'b0);
        req = 8'h00;
        tick();
        chk1("t1_valid", code_valid, 1'b1);
        chk3("t1_code", code, 3'd5);
        code_ready = 1'b1;
        tick();
        chk8("t1_pending_clr", pending, 8'h00);
        chk1("t1_valid_clr", code_valid, 1'b0);
        code_ready = 1'b0;
        tick();

        // 2: simultaneous rises on 1, 3, 6 -> 6, 3, 1
        req = 8'h4A;
        tick();
        chk8("t2_pending", pending, 8'h4A);
        req = 8'h00;
        tick();
        chk1("t2_valid6", code_valid, 1'b1);
        chk3("t2_code6", code, 3'd6);
        tick();
        chk3("t2_hold6", code, 3'd6);
        chk1("t2_holdv6", code_valid, 1'b1);
        code_ready = 1'b1;
        tick();
        chk1("t2_idle1", code_valid, 1'b0);
        chk8("t2_pend_a", pending, 8'h0A);
        tick();
        chk1("t2_valid3", code_valid, 1'b1);
        chk3("t2_code3", code, 3'd3);
        tick();
        chk1("t2_idle2", code_valid, 1'b0);
        chk8("t2_pend_b", pending, 8'h02);
        chk3("t2_code_keep", code, 3'd3);
        tick();
        chk1("t2_valid1", code_valid, 1'b1);
        chk3("t2_code1", code, 3'd1);
        tick();
        chk1("t2_done", code_valid, 1'b0);
        chk8("t2_pend_c", pending, 8'h00);
        code_ready = 1'b0;
        tick();

        // 3: no preemption by higher-priority arrival
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        chk3("t3_code4", code, 3'd4);
        req = 8'h80;
        tick();
        chk8("t3_pending", pending, 8'h90);
        chk3("t3_still4", code, 3'd4);
        chk1("t3_valid", code_valid, 1'b1);
        req = 8'h00;
        tick();
        chk3("t3_still4b", code, 3'd4);
        code_ready = 1'b1;
        tick();
        chk1("t3_idle", code_valid, 1'b0);
        chk8("t3_pend80", pending, 8'h80);
        tick();
        chk3("t3_code7", code, 3'd7);
        chk1("t3_valid7", code_valid, 1'b1);
        tick();
        chk8("t3_pend0", pending, 8'h00);
        code_ready = 1'b0;
        tick();

        // 4: re-rise on a pending bit pulses lost once, only one code issued
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        chk3("t4_code2", code, 3'd2);
        chk1("t4_lost0", lost, 1'b0);
        req = 8'h04;
        tick();
        chk1("t4_lost1", lost, 1'b1);
        chk8("t4_pending", pending, 8'h04);
        req = 8'h00;
        tick();
        chk1("t4_lost_end", lost, 1'b0);
        code_ready = 1'b1;
        tick();
        chk8("t4_pend0", pending, 8'h00);
        tick();
        chk1("t4_no_second", code_valid, 1'b0);
        tick();
        chk1("t4_no_second_b", code_valid, 1'b0);
        code_ready = 1'b0;

        // 5: rise on req[0] while code 0 is being accepted -> re-presented
        req = 8'h01;
        tick();
        req = 8'h00;
        tick();
        chk3("t5_code0", code, 3'd0);
        chk1("t5_valid", code_valid, 1'b1);
        req = 8'h01;
        code_ready = 1'b1;
        tick();
        chk8("t5_set_wins", pending, 8'h01);
        chk1("t5_valid_drop", code_valid, 1'b0);
        chk1("t5_lost", lost, 1'b0);
        req = 8'h00;
        code_ready = 1'b0;
        tick();
        chk1("t5_repres", code_valid, 1'b1);
        chk3("t5_code0b", code, 3'd0);
        code_ready = 1'b1;
        tick();
        chk8("t5_pend0", pending, 8'h00);
        code_ready = 1'b0;
        tick();

        // 6: disabled capture, then async reset while presenting
        enable = 1'b0;
        req = 8'h10;
        tick();
        chk8("t6_nocap", pending, 8'h00);
        req = 8'h00;
        tick();
        chk1("t6_novalid", code_valid, 1'b0);
        chk8("t6_nocap_b", pending, 8'h00);
        enable = 1'b1;
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        chk1("t6_present", code_valid, 1'b1);
        chk3("t6_code5", code, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_valid", code_valid, 1'b0);
        chk3("t6_rst_code", code, 3'd0);
        chk8("t6_rst_pending", pending, 8'h00);
        chk1("t6_rst_lost", lost, 1'b0);

        // req held high through reset counts as a rise once released
        req = 8'h08;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk8("t6_held_rise", pending, 8'h08);
        tick();
        chk3("t6_code3", code, 3'd3);
        chk1("t6_valid3", code_valid, 1'b1);
        code_ready = 1'b1;
        tick();
        chk8("t6_pend0", pending, 8'h00);
        chk1("t6_lost_held", lost, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
